latch_fifo: RTL and testbench
=============================

Name: latch_fifo

Overview:
Parametrised successor to the single-entry 128-bit capture latch. Buffers up to DEPTH words of DATA_W bits with ready/valid handshakes on both sides. Keeps the team's enable/clear control semantics and adds occupancy reporting and sticky overflow detection. Sits between a bursty producer (e.g. cipher/datapath output) and a consumer that may stall.

Parameters:
DATA_W, 128, data word width in bits (>=1)
DEPTH, 4, number of storage entries (power of 2, >=2); CNT_W = $clog2(DEPTH+1) is a derived localparam

Ports:
clk  input  1  clock, all state updates on rising edge
resetn  input  1  asynchronous active-low reset
enable_i  input  1  push enable; 0 blocks new writes, reads unaffected
clear_i  input  1  synchronous clear, highest priority after reset
d_i  input  DATA_W  write data
valid_i  input  1  write request
ready_o  output  1  write accept = enable_i && !full
d_o  output  DATA_W  head-of-queue data
valid_o  output  1  head valid = !empty
ready_i  input  1  consumer accepts head
count_o  output  CNT_W  current occupancy, 0..DEPTH
overflow_o  output  1  sticky: write attempted while full

Behaviour:
- Reset (resetn=0, async): write/read pointers=0, count_o=0, valid_o=0, overflow_o=0, all storage entries=0, so d_o=0. ready_o follows enable_i.
- push = valid_i && ready_o; pop = valid_o && ready_i. Both evaluated in the same cycle.
- push: d_i written at wr_ptr; wr_ptr increments modulo DEPTH.
- pop: rd_ptr increments modulo DEPTH.
- count_o: +1 on push only, -1 on pop only, unchanged on push && pop.
- Latency: a word accepted in cycle N appears on d_o with valid_o=1 in cycle N+1 (empty case). Order is strict FIFO.
- d_o = storage[rd_ptr] combinationally. It is stable while valid_o && !ready_i.
- full (count_o==DEPTH): ready_o=0, including on a cycle that pops. No push-while-full pass-through.
- Overflow: valid_i && enable_i && full sets overflow_o on the next edge. overflow_o stays set until clear_i or reset. The attempted word is dropped and state is unchanged.
- enable_i=0: ready_o=0 and no push. valid_i is ignored and does not set overflow. Pops continue normally.
- Empty: valid_o=0 and pop is impossible. The ready_i value is irrelevant.
- clear_i=1 on an edge: pointers, count, overflow_o and all storage go to 0 (d_o=0, valid_o=0). Any push or pop in the same cycle is discarded.
- Reset asserted mid-transfer: all state is lost immediately and no partial writes remain.
- Pointer wrap: after DEPTH pushes, wr_ptr returns to 0. The full/empty decision uses count, not pointer equality.

Optional Feature:
LATCH_FIFO_BYPASS_EN
- Defined: zero-latency bypass when the queue is empty.
  - While count_o==0 && valid_i && enable_i: valid_o=1 and d_o=d_i in the same cycle.
  - If ready_i=1 in that cycle, the word is consumed directly and is not written; count_o stays 0.
  - If ready_i=0, the word is written normally and count_o becomes 1.
- Undefined: no combinational path from d_i/valid_i to d_o/valid_o. Minimum latency is 1 cycle as above.

Test Plan:
- Reset: assert resetn=0 with enable_i=1 -> d_o=0, valid_o=0, count_o=0, overflow_o=0, ready_o=1.
- Fill/drain, DEPTH=4, ready_i=0:
  - Push 0xA0..0xA3 -> count_o=4, ready_o=0.
  - Then ready_i=1 -> d_o presents 0xA0, 0xA1, 0xA2, 0xA3 on successive cycles, then valid_o=0.
- Overflow: with the queue full, drive valid_i=1 with d_i=0xFF for one cycle -> overflow_o=1 next cycle, count_o stays 4, 0xFF never appears on d_o. Then pulse clear_i -> overflow_o=0, count_o=0, d_o=0.
- Simultaneous push/pop: at count_o=2, push 0xB0 while popping -> count_o stays 2, and 0xB0 emerges after the two older words.
- Enable gating and wrap:
  - enable_i=0 with valid_i=1 -> ready_o=0, no count change, overflow_o stays 0.
  - Then stream 10 words with ready_i=1 -> all 10 delivered in order across pointer wrap.
- Bypass (macro defined): empty queue, valid_i=1, d_i=0xC5, ready_i=1 -> valid_o=1 and d_o=0xC5 in the same cycle, count_o stays 0.

Source files
------------

// File: rtl/latch_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : latch_fifo
//  Purpose  : DEPTH-entry ready/valid FIFO that replaces the single-entry
//             capture latch. Keeps the enable/clear control semantics, adds
//             occupancy reporting and sticky overflow detection.
//  Options  : LATCH_FIFO_BYPASS_EN - when defined, a word offered to an empty
//             queue is presented on d_o in the same cycle and, if taken,
//             never occupies storage.
//  Revision : 1.0 - initial parametrised release
// ============================================================================
module latch_fifo #(
    parameter int DATA_W = 128,
    parameter int DEPTH  = 4
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       enable_i,
    input  logic                       clear_i,
    input  logic [DATA_W-1:0]          d_i,
    input  logic                       valid_i,
    output logic                       ready_o,
    output logic [DATA_W-1:0]          d_o,
    output logic                       valid_o,
    input  logic                       ready_i,
    output logic [$clog2(DEPTH+1)-1:0] count_o,
    output logic                       overflow_o
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = $clog2(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q,  count_d;
    logic              ovf_q,    ovf_d;

    logic w_full;
    logic w_empty;
    logic w_push;
    logic w_pop;
    logic w_direct;
    logic w_store;
    logic w_take;

    // Full/empty come from the occupancy counter; pointers are equal in both.
    assign w_full  = (count_q == CNT_W'(DEPTH));
    assign w_empty = (count_q == '0);

    assign ready_o = enable_i && !w_full;

`ifdef LATCH_FIFO_BYPASS_EN
    logic w_bypass;
    // An empty queue forwards the offered word straight to the consumer.
    assign w_bypass = w_empty && valid_i && enable_i;
    assign valid_o  = !w_empty || w_bypass;
    assign d_o      = w_bypass ? d_i : mem_q[rd_ptr_q];
    // Word handed over directly: neither stored nor popped from storage.
    assign w_direct = w_bypass && ready_i;
`else
    assign valid_o  = !w_empty;
    assign d_o      = mem_q[rd_ptr_q];
    assign w_direct = 1'b0;
`endif

    assign w_push  = valid_i && ready_o;
    assign w_pop   = valid_o && ready_i;
    assign w_store = w_push && !w_direct;
    assign w_take  = w_pop  && !w_direct;

    assign count_o    = count_q;
    assign overflow_o = ovf_q;

    // Next-state for pointers, occupancy and the sticky overflow flag.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        if (w_store) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (w_take) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({w_store, w_take})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        // A write offered while full is dropped but remembered.
        if (valid_i && enable_i && w_full) begin
            ovf_d = 1'b1;
        end
    end

    // Control state: async reset, then synchronous clear, then normal update.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else if (clear_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
        end
    end

    // Storage is zeroed on reset/clear so an idle d_o reads back as 0.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (clear_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (w_store) begin
            mem_q[wr_ptr_q] <= d_i;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_latch_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : tb_latch_fifo
//  Purpose  : Self-checking bench for latch_fifo: directed vector table,
//             hand-written corner sequences and a randomized run against a
//             queue-based reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_latch_fifo;

    localparam int DW    = 16;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH + 1);
`ifdef LATCH_FIFO_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic          clk    = 1'b0;
    logic          resetn = 1'b0;
    logic          en     = 1'b1;
    logic          clr    = 1'b0;
    logic          vi     = 1'b0;
    logic          ri     = 1'b0;
    logic [DW-1:0] di     = '0;
    logic          ready_o;
    logic [DW-1:0] d_o;
    logic          valid_o;
    logic [CW-1:0] count_o;
    logic          overflow_o;

    int nchk  = 0;
    int npass = 0;

    // Reference model: contents in arrival order, sticky flag, and whether
    // storage is still all-zero since the last reset/clear.
    logic [DW-1:0] mq [$];
    bit            m_ovf;
    bit            m_zero;

    always #5 clk = ~clk;

    latch_fifo #(.DATA_W(DW), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .enable_i   (en),
        .clear_i    (clr),
        .d_i        (di),
        .valid_i    (vi),
        .ready_o    (ready_o),
        .d_o        (d_o),
        .valid_o    (valid_o),
        .ready_i    (ri),
        .count_o    (count_o),
        .overflow_o (overflow_o)
    );

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        nchk++;
        if (act === exp) npass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic bit e_ready();
        return en && (mq.size() < DEPTH);
    endfunction

    function automatic bit e_byp();
        return BYP && (mq.size() == 0) && vi && en;
    endfunction

    function automatic bit e_valid();
        return (mq.size() > 0) || e_byp();
    endfunction

    function automatic logic [DW-1:0] e_d();
        if (mq.size() > 0) return mq[0];
        if (e_byp()) return di;
        return '0;
    endfunction

    task automatic model_reset();
        mq.delete();
        m_ovf  = 1'b0;
        m_zero = 1'b1;
    endtask

    // Apply the spec's edge rules to the model with the inputs currently held.
    task automatic model_edge();
        bit push, pop, direct;
        if (clr) begin
            model_reset();
        end else begin
            push   = vi && e_ready();
            pop    = e_valid() && ri;
            direct = e_byp() && ri;
            if (en && vi && mq.size() == DEPTH) m_ovf = 1'b1;
            if (!direct) begin
                if (pop)  void'(mq.pop_front());
                if (push) begin
                    mq.push_back(di);
                    m_zero = 1'b0;
                end
            end
        end
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".ready"}, DW'(ready_o), DW'(e_ready()));
        chk({tag, ".valid"}, DW'(valid_o), DW'(e_valid()));
        chk({tag, ".count"}, DW'(count_o), DW'(mq.size()));
        chk({tag, ".ovf"},   DW'(overflow_o), DW'(m_ovf));
        if (e_valid() || m_zero) chk({tag, ".d"}, d_o, e_d());
    endtask

    // Inputs already applied just after a falling edge.
    task automatic cycle(input string tag);
        #1;
        check_model(tag);
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    typedef struct {
        bit            en;
        bit            clr;
        bit            v;
        bit            r;
        logic [DW-1:0] d;
        bit            xr;
        bit            xv;
        logic [DW-1:0] xd;
        int            xc;
        bit            xo;
    } vec_t;

    localparam int NV = 21;
    vec_t tv [NV];

    logic [DW-1:0] rx [$];

    initial begin
        // Directed table: outputs expected before each edge.
        tv[0]  = '{1,0,1,0,16'h00A0, 1,BYP,(BYP ? 16'h00A0 : 16'h0000),0,0};
        tv[1]  = '{1,0,1,0,16'h00A1, 1,1,16'h00A0,1,0};
        tv[2]  = '{1,0,1,0,16'h00A2, 1,1,16'h00A0,2,0};
        tv[3]  = '{1,0,1,0,16'h00A3, 1,1,16'h00A0,3,0};
        tv[4]  = '{1,0,1,0,16'h00FF, 0,1,16'h00A0,4,0};
        tv[5]  = '{1,0,0,0,16'h0000, 0,1,16'h00A0,4,1};
        tv[6]  = '{1,0,0,1,16'h0000, 0,1,16'h00A0,4,1};
        tv[7]  = '{1,0,0,1,16'h0000, 1,1,16'h00A1,3,1};
        tv[8]  = '{1,0,0,1,16'h0000, 1,1,16'h00A2,2,1};
        tv[9]  = '{1,0,0,1,16'h0000, 1,1,16'h00A3,1,1};
        tv[10] = '{1,0,0,1,16'h0000, 1,0,16'h00A0,0,1};
        tv[11] = '{1,1,0,0,16'h0000, 1,0,16'h00A0,0,1};
        tv[12] = '{1,0,0,0,16'h0000, 1,0,16'h0000,0,0};
        tv[13] = '{1,0,1,0,16'h00B1, 1,BYP,(BYP ? 16'h00B1 : 16'h0000),0,0};
        tv[14] = '{1,0,1,0,16'h00B2, 1,1,16'h00B1,1,0};
        tv[15] = '{1,0,1,1,16'h00B0, 1,1,16'h00B1,2,0};
        tv[16] = '{1,0,0,1,16'h0000, 1,1,16'h00B2,2,0};
        tv[17] = '{1,0,0,1,16'h0000, 1,1,16'h00B0,1,0};
        tv[18] = '{1,0,0,0,16'h0000, 1,0,16'h0000,0,0};
        tv[19] = '{0,0,1,0,16'h0055, 0,0,16'h0000,0,0};
        tv[20] = '{0,0,1,0,16'h0056, 0,0,16'h0000,0,0};

        // Reset state with enable high.
        model_reset();
        #2;
        chk("rst.d",     d_o, 16'h0000);
        chk("rst.valid", DW'(valid_o), 16'h0000);
        chk("rst.count", DW'(count_o), 16'h0000);
        chk("rst.ovf",   DW'(overflow_o), 16'h0000);
        chk("rst.ready", DW'(ready_o), 16'h0001);
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);

        for (int i = 0; i < NV; i++) begin
            en = tv[i].en; clr = tv[i].clr; vi = tv[i].v; ri = tv[i].r; di = tv[i].d;
            #1;
            chk($sformatf("tv%0d.ready", i), DW'(ready_o), DW'(tv[i].xr));
            chk($sformatf("tv%0d.valid", i), DW'(valid_o), DW'(tv[i].xv));
            chk($sformatf("tv%0d.d", i),     d_o, tv[i].xd);
            chk($sformatf("tv%0d.count", i), DW'(count_o), DW'(tv[i].xc));
            chk($sformatf("tv%0d.ovf", i),   DW'(overflow_o), DW'(tv[i].xo));
            @(posedge clk);
            model_edge();
            @(negedge clk);
        end

        // Stream 10 words with the consumer always ready, across pointer wrap.
        en = 1'b1; clr = 1'b0; ri = 1'b1;
        rx.delete();
        for (int i = 0; i < 14; i++) begin
            vi = (i < 10);
            di = (i < 10) ? DW'(16'hD000 + i) : '0;
            #1;
            if (valid_o && ri) rx.push_back(d_o);
            check_model("stream");
            @(posedge clk);
            model_edge();
            @(negedge clk);
        end
        chk("stream.n", DW'(rx.size()), 16'd10);
        for (int i = 0; i < 10; i++) begin
            if (i < rx.size()) chk($sformatf("stream.w%0d", i), rx[i], DW'(16'hD000 + i));
        end

        // Offer to an empty queue with the consumer ready (bypass corner).
        vi = 1'b1; di = 16'h00C5; ri = 1'b1;
        cycle("emptyoffer");
        vi = 1'b0; ri = 1'b0;
        cycle("emptyoffer.after");
        ri = 1'b1;
        cycle("emptyoffer.drain");
        ri = 1'b0;

        // Reset asserted mid-transfer takes effect without a clock edge.
        vi = 1'b1; di = 16'h00E1;
        cycle("prerst0");
        di = 16'h00E2;
        cycle("prerst1");
        vi = 1'b0;
        #2;
        resetn = 1'b0;
        #1;
        chk("async.count", DW'(count_o), 16'h0000);
        chk("async.valid", DW'(valid_o), 16'h0000);
        chk("async.d",     d_o, 16'h0000);
        model_reset();
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);

        // Randomized traffic against the reference model.
        for (int i = 0; i < 400; i++) begin
            en  = ($urandom_range(0, 7) != 0);
            clr = ($urandom_range(0, 39) == 0);
            vi  = ($urandom_range(0, 9) < 6);
            ri  = ($urandom_range(0, 9) < 5);
            di  = DW'($urandom);
            cycle("rand");
        end

        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

endmodule
`default_nettype wire
